// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the MEM-stage SRAM controller:
//   - state_e          : FSM state encoding (IDLE=0, LO=1, HI=2, DONE=3)
//   - MEM_BASE_DEFAULT : byte address that maps to SRAM word 0
//   - CNT_W            : width of the per-phase wait counter
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned MEM_BASE_DEFAULT = 1024;
  localparam int unsigned CNT_W            = 4;

endpackage : sram_ctrl_pkg

// File: rtl/sram_phase_counter.sv
// -----------------------------------------------------------------------------
// sram_phase_counter
// Counts the SRAM cycles spent in one 16-bit half transfer.
// Ports:
//   clock   in   system clock, rising edge
//   reset   in   synchronous, active-high
//   clr_i   in   force count to 0 (has priority over en_i)
//   en_i    in   increment count
//   cnt_o   out  current count
//   last_o  out  1 when the count sits on the final cycle of a phase
// -----------------------------------------------------------------------------
module sram_phase_counter
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == LAST_CNT);

endmodule : sram_phase_counter

// File: rtl/sram_mem_controller.sv
// -----------------------------------------------------------------------------
// sram_mem_controller
// Serves each 32-bit MEM-stage load/store as two 16-bit transfers (LO half,
// then HI half) on an external asynchronous SRAM. ready stays low while an
// access is in flight so the pipeline freezes.
// Ports:
//   clock, reset          system clock / synchronous active-high reset
//   rd_en, wr_en          load / store request, held until ready=1
//   address, write_data   byte address and store value
//   read_data             load result, valid in DONE, held until next load
//   ready                 1 = idle with no request, or completing this cycle
//   sram_addr             {word_index, half_select}
//   sram_dq_out/_oe       write half-word and its output enable
//   sram_dq_in            read half-word from the SRAM
//   sram_we_n             active-low write strobe
// -----------------------------------------------------------------------------
module sram_mem_controller
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned MEM_BASE    = MEM_BASE_DEFAULT,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  localparam int unsigned      IDX_W    = SRAM_AW - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               write_q, write_d;
  logic [15:0]        lo_q, lo_d;
  logic [31:0]        read_data_q, read_data_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]        dq_out_q, dq_out_d;
  logic               oe_q, oe_d;
  logic               we_n_q, we_n_d;

  logic             req;
  logic             cnt_clr, cnt_en;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             cnt_last, last_nxt;
  logic             busy_nxt;
  logic [IDX_W-1:0] idx_new;

  assign req     = rd_en | wr_en;
  // Word index wraps modulo the SRAM size for out-of-range addresses.
  assign idx_new = IDX_W'((address - 32'(MEM_BASE)) >> 2);

  sram_phase_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_phase_cnt (
    .clock  (clock),
    .reset  (reset),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (cnt),
    .last_o (cnt_last)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    lo_d        = lo_q;
    read_data_d = read_data_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (req) begin
          // Request is captured here; later changes on the inputs are ignored.
          state_d = ST_LO;
          idx_d   = idx_new;
          wdata_d = write_data;
          write_d = wr_en;
        end
      end
      ST_LO: begin
        if (cnt_last) begin
          state_d = ST_HI;
          cnt_clr = 1'b1;
          if (!write_q) lo_d = sram_dq_in;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_HI: begin
        if (cnt_last) begin
          state_d = ST_DONE;
          cnt_clr = 1'b1;
          if (!write_q) read_data_d = {sram_dq_in, lo_q};
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        // Never re-arms directly; the next request is seen from IDLE.
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // SRAM pins are registered, so they are computed from the state and count
    // the controller will hold during the next cycle.
    cnt_nxt  = cnt_clr ? '0 : (cnt_en ? cnt + CNT_W'(1) : cnt);
    last_nxt = (cnt_nxt == LAST_CNT);
    busy_nxt = (state_d == ST_LO) || (state_d == ST_HI);

    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    if (busy_nxt) begin
      sram_addr_d = {idx_d, (state_d == ST_HI)};
      dq_out_d    = (state_d == ST_HI) ? wdata_d[31:16] : wdata_d[15:0];
    end
    oe_d   = busy_nxt & write_d;
    // Strobe released on the last cycle of each phase while addr/data/oe stay
    // put, giving hold time past the rising edge of we_n.
    we_n_d = ~(busy_nxt & write_d & ~last_nxt);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      lo_q        <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      oe_q        <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      lo_q        <= lo_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      oe_q        <= oe_d;
      we_n_q      <= we_n_d;
    end
  end

  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      ST_IDLE: ready = ~req;
      ST_DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;

endmodule : sram_mem_controller

// File: tb/tb_sram_mem_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_mem_controller
// Directed and random loads/stores against sram_mem_controller with a small
// asynchronous SRAM model and a word-level reference memory.
// -----------------------------------------------------------------------------
module tb_sram_mem_controller;

  localparam int unsigned W    = 2;
  localparam int unsigned BASE = 1024;

  logic        clock = 1'b0;
  logic        reset;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  int total = 0;
  int bad   = 0;

  // SRAM model: 256 half-words; low address bits select the entry.
  logic [15:0] sram [256] = '{default: 16'h0000};
  int          we_low_cycles = 0;
  int          oe_cycles     = 0;

  // Reference: 32-bit words by word index, plus last load result.
  logic [31:0] model_mem [int];
  logic [31:0] exp_rd = 32'h0;

  always #5 clock = ~clock;

  assign sram_dq_in = sram[sram_addr[7:0]];

  always @(negedge clock) begin
    if (!sram_we_n) begin
      sram[sram_addr[7:0]] = sram_dq_out;
      we_low_cycles++;
    end
    if (sram_dq_oe) oe_cycles++;
  end

  sram_mem_controller #(
    .WAIT_CYCLES (W),
    .MEM_BASE    (BASE),
    .SRAM_AW     (18)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input int idx);
    if (model_mem.exists(idx)) return model_mem[idx];
    return 32'h0;
  endfunction

  // One access. Call at a negedge (+small offset). With b2b=1 the controller
  // is in DONE, so the request is first seen in the following IDLE cycle.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input bit b2b, input bit drop);
    int          low;
    int          widx;
    bit          is_wr;
    logic [17:0] addr_lo;
    rd_en      = rd;
    wr_en      = wr;
    address    = a;
    write_data = d;
    is_wr      = wr;
    widx       = int'(((a - BASE) >> 2) & 32'h1FFFF);
    if (b2b) @(negedge clock);
    #1;
    we_low_cycles = 0;
    oe_cycles     = 0;
    low           = 0;
    addr_lo       = 'x;
    while (!ready && low < 100) begin
      low++;
      if (low == 2) addr_lo = sram_addr;
      @(negedge clock);
      #1;
    end
    // Now in the DONE cycle.
    check("latency", 32'(low), 32'(2 * W + 1));
    check("lo_addr", 32'(addr_lo), 32'(widx * 2));
    check("we_low_cycles", 32'(we_low_cycles), is_wr ? 32'(2 * (W - 1)) : 32'h0);
    check("oe_cycles", 32'(oe_cycles), is_wr ? 32'(2 * W) : 32'h0);
    if (is_wr) begin
      model_mem[widx] = d;
      if (widx < 128) begin
        check("sram_lo", 32'(sram[2 * widx]), 32'(d[15:0]));
        check("sram_hi", 32'(sram[2 * widx + 1]), 32'(d[31:16]));
      end
    end else begin
      exp_rd = model_rd(widx);
    end
    check(is_wr ? "rd_data_kept" : "rd_data", read_data, exp_rd);
    if (drop) begin
      rd_en = 1'b0;
      wr_en = 1'b0;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] snap;
    int          wait_cnt;

    reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
    address = '0; write_data = '0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check("rst_ready", 32'(ready), 32'h1);
    check("rst_we_n", 32'(sram_we_n), 32'h1);
    check("rst_oe", 32'(sram_dq_oe), 32'h0);
    check("rst_read_data", read_data, 32'h0);
    check("rst_sram_addr", 32'(sram_addr), 32'h0);
    reset = 1'b0;

    // Store then load the first word.
    @(negedge clock);
    access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0, 1'b1);
    check("sram0", 32'(sram[0]), 32'h0000BEEF);
    check("sram1", 32'(sram[1]), 32'h0000DEAD);
    @(negedge clock);
    access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, 1'b1);
    check("load_1024", read_data, 32'hDEADBEEF);
    repeat (3) @(negedge clock);
    check("read_hold", read_data, 32'hDEADBEEF);
    check("idle_ready", 32'(ready), 32'h1);

    // Back-to-back store/load.
    @(negedge clock);
    access(1'b0, 1'b1, 32'd1028, 32'h12345678, 1'b0, 1'b0);
    access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, 1'b1);
    check("b2b_load", read_data, 32'h12345678);
    check("sram2", 32'(sram[2]), 32'h00005678);
    check("sram3", 32'(sram[3]), 32'h00001234);

    // rd_en and wr_en together act as a write.
    @(negedge clock);
    access(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, 1'b0, 1'b1);
    check("both_sram4", 32'(sram[4]), 32'h00005A5A);
    check("both_sram5", 32'(sram[5]), 32'h0000A5A5);
    check("both_rd_kept", read_data, 32'h12345678);

    // Address below the base wraps to the top of the SRAM.
    @(negedge clock);
    access(1'b0, 1'b1, 32'd1020, 32'h0BADC0DE, 1'b0, 1'b1);
    check("wrap_lo", 32'(sram[8'hFE]), 32'h0000C0DE);
    check("wrap_hi", 32'(sram[8'hFF]), 32'h00000BAD);

    // Random traffic, some of it back-to-back.
    @(negedge clock);
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      bit          r, w, b;
      a = BASE + ($urandom_range(0, 31) * 4) + $urandom_range(0, 3);
      w = $urandom_range(0, 1) == 1;
      r = !w || ($urandom_range(0, 3) == 0);
      b = (i > 0) && ($urandom_range(0, 1) == 1);
      if (!b) begin
        rd_en = 1'b0;
        wr_en = 1'b0;
        @(negedge clock);
      end
      access(r, w, a, $urandom, b, 1'b0);
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
    @(negedge clock);

    // Reset during the HI phase of a store.
    access(1'b1, 1'b0, 32'd1040, 32'h0, 1'b0, 1'b1);
    @(negedge clock);
    rd_en = 1'b0; wr_en = 1'b1; address = 32'd1040; write_data = 32'hCAFEF00D;
    #1;
    wait_cnt = 0;
    while (!(sram_dq_oe && sram_addr[0]) && wait_cnt < 20) begin
      wait_cnt++;
      @(negedge clock);
      #1;
    end
    check("reach_hi", 32'(wait_cnt < 20), 32'h1);
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("abort_we_n", 32'(sram_we_n), 32'h1);
    check("abort_oe", 32'(sram_dq_oe), 32'h0);
    check("abort_read_data", read_data, 32'h0);
    check("abort_sram_addr", 32'(sram_addr), 32'h0);
    snap  = sram[9];
    reset = 1'b0;
    wr_en = 1'b0;
    #1;
    check("abort_ready", 32'(ready), 32'h1);
    we_low_cycles = 0;
    repeat (4) @(negedge clock);
    #1;
    check("abort_no_strobe", 32'(we_low_cycles), 32'h0);
    check("abort_sram_hi", 32'(sram[9]), 32'(snap));
    check("abort_idle_ready", 32'(ready), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sram_mem_controller
